// File: rtl/clock_pkg.sv
// Shared types, field limits and calendar helper for the set-field editor.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EDIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    TGT_NONE  = 2'b00,
    TGT_TIME  = 2'b01,
    TGT_DATE  = 2'b10,
    TGT_ALARM = 2'b11
  } tgt_e;

  localparam logic [6:0] HOUR_MAX  = 7'd23;
  localparam logic [6:0] MIN_MAX   = 7'd59;
  localparam logic [6:0] SEC_MAX   = 7'd59;
  localparam logic [6:0] YEAR_MAX  = 7'd99;
  localparam logic [6:0] MONTH_MIN = 7'd1;
  localparam logic [6:0] MONTH_MAX = 7'd12;
  localparam logic [6:0] DAY_MIN   = 7'd1;

  // Century 2000-2099: every year divisible by four is leap.
  function automatic logic [6:0] days_in_month(input logic [6:0] year, input logic [6:0] month);
    case (month)
      7'd2:                    days_in_month = (year[1:0] == 2'b00) ? 7'd29 : 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11: days_in_month = 7'd30;
      default:                 days_in_month = 7'd31;
    endcase
  endfunction

endpackage

// File: rtl/set_field_controller_key_repeat.sv
// Key event generator: one pulse on press, then auto-repeat while held.
module key_repeat
  import clock_pkg::*;
#(
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic key,
  output logic evt
);

  localparam int CW = $clog2(((HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS) + 1);

  logic          r_key_d;
  logic          r_rep;
  logic [CW-1:0] r_cnt;
  logic          w_rise;
  logic          w_hit;
  logic [CW-1:0] w_lim;
  logic [CW-1:0] w_cnt_inc;

  assign w_rise    = key & ~r_key_d;
  assign w_lim     = r_rep ? CW'(REPEAT_MS) : CW'(HOLD_MS);
  assign w_cnt_inc = r_cnt + CW'(1);
  // The press edge restarts timing, so a tick in that cycle is not counted.
  assign w_hit     = key & ~w_rise & tick_ms & (w_cnt_inc == w_lim);
  assign evt       = w_rise | w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_d <= 1'b0;
      r_rep   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_key_d <= key;
      if (!key || w_rise) begin
        r_rep <= 1'b0;
        r_cnt <= '0;
      end else if (tick_ms) begin
        if (w_hit) begin
          r_rep <= 1'b1;
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/set_field_controller.sv
// Field-by-field editor for time/date/alarm with valid/ready commit.
// Define SET_FIELD_DEC_KEY_EN to add a key_dec port with decrement support.
module set_field_controller
  import clock_pkg::*;
#(
  parameter int HOLD_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_ms,
  input  logic       set_time_en,
  input  logic       set_date_en,
  input  logic       set_alarm_en,
  input  logic       key_next,
  input  logic       key_inc,
`ifdef SET_FIELD_DEC_KEY_EN
  input  logic       key_dec,
`endif
  input  logic [6:0] snap_f0,
  input  logic [6:0] snap_f1,
  input  logic [6:0] snap_f2,
  output logic [6:0] edit_f0,
  output logic [6:0] edit_f1,
  output logic [6:0] edit_f2,
  output logic [2:0] field_sel,
  output logic       wr_valid,
  output logic [1:0] wr_target,
  input  logic       wr_ready
);

  state_e     r_state;
  tgt_e       r_mode;
  tgt_e       r_tgt;
  tgt_e       w_req;
  logic [6:0] r_f0, r_f1, r_f2;
  logic [2:0] r_sel;
  logic       r_dirty;
  logic       r_valid;
  logic       r_next_d;

  logic       w_inc_evt, w_do_inc, w_dec, w_bump, w_next;
  logic [6:0] w_cur, w_lo, w_hi, w_val, w_dim, w_ndim;
  logic [6:0] w_n0, w_n1, w_n2;

  key_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)) u_inc (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .key(key_inc), .evt(w_inc_evt)
  );

`ifdef SET_FIELD_DEC_KEY_EN
  logic w_dec_evt;
  key_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)) u_dec (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .key(key_dec), .evt(w_dec_evt)
  );
  // Opposing events in one cycle cancel out entirely.
  assign w_do_inc = w_inc_evt & ~w_dec_evt;
  assign w_dec    = w_dec_evt & ~w_inc_evt;
`else
  assign w_do_inc = w_inc_evt;
  assign w_dec    = 1'b0;
`endif

  assign w_bump = w_do_inc | w_dec;
  assign w_next = key_next & ~r_next_d;
  assign w_dim  = days_in_month(r_f0, r_f1);

  always_comb begin
    w_req = TGT_NONE;
    if (set_time_en)       w_req = TGT_TIME;
    else if (set_date_en)  w_req = TGT_DATE;
    else if (set_alarm_en) w_req = TGT_ALARM;
  end

  always_comb begin
    w_cur = r_sel[0] ? r_f0 : (r_sel[1] ? r_f1 : r_f2);
    w_lo  = 7'd0;
    w_hi  = HOUR_MAX;
    if (r_mode == TGT_DATE) begin
      if (r_sel[0]) begin
        w_hi = YEAR_MAX;
      end else if (r_sel[1]) begin
        w_lo = MONTH_MIN;
        w_hi = MONTH_MAX;
      end else begin
        w_lo = DAY_MIN;
        w_hi = w_dim;
      end
    end else begin
      if (r_sel[1])      w_hi = MIN_MAX;
      else if (r_sel[2]) w_hi = SEC_MAX;
    end
    w_val = w_dec ? ((w_cur <= w_lo) ? w_hi : w_cur - 7'd1)
                  : ((w_cur >= w_hi) ? w_lo : w_cur + 7'd1);
    w_n0 = r_f0;
    w_n1 = r_f1;
    w_n2 = r_f2;
    if (r_sel[0])      w_n0 = w_val;
    else if (r_sel[1]) w_n1 = w_val;
    else               w_n2 = w_val;
    // Year or month change pulls the day back inside the new month.
    w_ndim = days_in_month(w_n0, w_n1);
    if (r_mode == TGT_DATE && !r_sel[2] && r_f2 > w_ndim) w_n2 = w_ndim;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mode   <= TGT_NONE;
      r_tgt    <= TGT_NONE;
      r_f0     <= '0;
      r_f1     <= '0;
      r_f2     <= '0;
      r_sel    <= '0;
      r_dirty  <= 1'b0;
      r_valid  <= 1'b0;
      r_next_d <= 1'b0;
    end else begin
      r_next_d <= key_next;
      case (r_state)
        ST_IDLE: begin
          if (w_req != TGT_NONE) begin
            r_mode  <= w_req;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_f0    <= snap_f0;
          r_f1    <= snap_f1;
          r_f2    <= (r_mode == TGT_ALARM) ? 7'd0 : snap_f2;
          r_sel   <= 3'b001;
          r_dirty <= 1'b0;
          r_state <= ST_EDIT;
        end
        ST_EDIT: begin
          if (w_req != r_mode) begin
            if (r_dirty) begin
              r_valid <= 1'b1;
              r_tgt   <= r_mode;
              r_state <= ST_COMMIT;
            end else begin
              r_sel   <= '0;
              r_state <= ST_IDLE;
            end
          end else if (w_next) begin
            r_sel <= (r_mode == TGT_ALARM) ? {1'b0, r_sel[0], r_sel[1]} : {r_sel[1:0], r_sel[2]};
          end else if (w_bump) begin
            r_f0    <= w_n0;
            r_f1    <= w_n1;
            r_f2    <= w_n2;
            r_dirty <= 1'b1;
          end
        end
        ST_COMMIT: begin
          if (wr_ready) begin
            r_valid <= 1'b0;
            r_tgt   <= TGT_NONE;
            r_sel   <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign edit_f0   = r_f0;
  assign edit_f1   = r_f1;
  assign edit_f2   = r_f2;
  assign field_sel = r_sel;
  assign wr_valid  = r_valid;
  assign wr_target = r_tgt;

endmodule

// File: tb/tb_set_field_controller.sv
// Bench for set_field_controller: directed scenarios plus random traffic vs a behavioural model.
module tb_set_field_controller;

  localparam int HOLD = 500;
  localparam int REP  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_ms = 1'b0;
  logic       set_time_en = 1'b0, set_date_en = 1'b0, set_alarm_en = 1'b0;
  logic       key_next = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic [6:0] snap_f0 = '0, snap_f1 = '0, snap_f2 = '0;
  logic [6:0] edit_f0, edit_f1, edit_f2;
  logic [2:0] field_sel;
  logic       wr_valid;
  logic [1:0] wr_target;
  logic       wr_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_field_controller #(.HOLD_MS(HOLD), .REPEAT_MS(REP)) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms),
    .set_time_en(set_time_en), .set_date_en(set_date_en), .set_alarm_en(set_alarm_en),
    .key_next(key_next), .key_inc(key_inc),
`ifdef SET_FIELD_DEC_KEY_EN
    .key_dec(key_dec),
`endif
    .snap_f0(snap_f0), .snap_f1(snap_f1), .snap_f2(snap_f2),
    .edit_f0(edit_f0), .edit_f1(edit_f1), .edit_f2(edit_f2),
    .field_sel(field_sel), .wr_valid(wr_valid), .wr_target(wr_target),
    .wr_ready(wr_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 loading, 2 editing, 3 committing; mode: 1 time, 2 date, 3 alarm
  int m_phase = 0, m_mode = 0, m_sel = -1, m_dirty = 0, m_valid = 0, m_tgt = 0;
  int m_f[3] = '{0, 0, 0};
  int m_pn = 0, m_pi = 0, m_ticks = 0;
  bit m_ok = 0;

  function automatic int dim_m(int y, int m);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    return t[m-1] + ((m == 2 && y % 4 == 0) ? 1 : 0);
  endfunction

  function automatic int hi_m(int mode, int i, int y, int mo);
    if (mode == 2) return (i == 0) ? 99 : ((i == 1) ? 12 : dim_m(y, mo));
    return (i == 0) ? 23 : 59;
  endfunction

  always @(posedge clk) begin : model
    int req, d, hi, lo;
    bit inc_evt, nx;
    if (rst) begin
      m_phase = 0; m_mode = 0; m_sel = -1; m_dirty = 0; m_valid = 0; m_tgt = 0;
      m_f = '{0, 0, 0}; m_pn = 0; m_pi = 0; m_ticks = 0; m_ok = 1;
    end else begin
      req = set_time_en ? 1 : (set_date_en ? 2 : (set_alarm_en ? 3 : 0));
      inc_evt = 0;
      if (key_inc && !m_pi) begin
        inc_evt = 1; m_ticks = 0;
      end else if (key_inc && tick_ms) begin
        m_ticks++;
        if (m_ticks == HOLD || (m_ticks > HOLD && (m_ticks - HOLD) % REP == 0)) inc_evt = 1;
      end
      if (!key_inc) m_ticks = 0;
      nx = key_next && !m_pn;
      case (m_phase)
        0: if (req != 0) begin m_mode = req; m_phase = 1; end
        1: begin
          m_f[0] = snap_f0; m_f[1] = snap_f1; m_f[2] = (m_mode == 3) ? 0 : snap_f2;
          m_sel = 0; m_dirty = 0; m_phase = 2;
        end
        2: begin
          if (req != m_mode) begin
            if (m_dirty) begin m_phase = 3; m_valid = 1; m_tgt = m_mode; end
            else begin m_phase = 0; m_sel = -1; end
          end else if (nx) begin
            m_sel = (m_sel + 1) % ((m_mode == 3) ? 2 : 3);
          end else if (inc_evt) begin
            hi = hi_m(m_mode, m_sel, m_f[0], m_f[1]);
            lo = (m_mode == 2 && m_sel > 0) ? 1 : 0;
            m_f[m_sel] = (m_f[m_sel] >= hi) ? lo : m_f[m_sel] + 1;
            if (m_mode == 2 && m_sel < 2) begin
              d = dim_m(m_f[0], m_f[1]);
              if (m_f[2] > d) m_f[2] = d;
            end
            m_dirty = 1;
          end
        end
        default: if (wr_ready) begin m_valid = 0; m_tgt = 0; m_sel = -1; m_phase = 0; end
      endcase
      m_pn = key_next; m_pi = key_inc;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmp_edit_f0", edit_f0, m_f[0]);
      chk("cmp_edit_f1", edit_f1, m_f[1]);
      chk("cmp_edit_f2", edit_f2, m_f[2]);
      chk("cmp_field_sel", field_sel, (m_sel < 0) ? 0 : (1 << m_sel));
      chk("cmp_wr_valid", wr_valid, m_valid);
      chk("cmp_wr_target", wr_target, m_tgt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic press_next();
    key_next = 1'b1; cyc(); key_next = 1'b0; cyc();
  endtask

  task automatic press_inc();
    key_inc = 1'b1; cyc(); key_inc = 1'b0; cyc();
  endtask

  task automatic wait_valid(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (wr_valid === 1'b1) begin seen = 1; break; end
      cyc();
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic handshake();
    wr_ready = 1'b1; cyc(); wr_ready = 1'b0; cyc();
  endtask

  initial begin
    bit seen;
    int m;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_edit_f0", edit_f0, 0);
    chk("rst_field_sel", field_sel, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_target", wr_target, 0);

    // Time wrap and commit
    snap_f0 = 7'd23; snap_f1 = 7'd59; snap_f2 = 7'd58;
    set_time_en = 1'b1; cyc(); cyc();
    chk("t1_snap_f0", edit_f0, 23);
    chk("t1_sel", field_sel, 1);
    press_inc(); press_next(); press_next(); press_inc();
    chk("t1_f0", edit_f0, 0);
    chk("t1_f1", edit_f1, 59);
    chk("t1_f2", edit_f2, 59);
    set_time_en = 1'b0; cyc();
    wait_valid("t1_valid");
    chk("t1_tgt", wr_target, 1);
    cyc(); cyc();
    chk("t1_held_valid", wr_valid, 1);
    chk("t1_held_f2", edit_f2, 59);
    handshake();
    chk("t1_done_valid", wr_valid, 0);
    chk("t1_done_sel", field_sel, 0);

    // Date clamp
    snap_f0 = 7'd23; snap_f1 = 7'd1; snap_f2 = 7'd31;
    set_date_en = 1'b1; cyc(); cyc();
    press_next(); press_inc();
    chk("t2_month", edit_f1, 2);
    chk("t2_day_clamp", edit_f2, 28);
    press_next(); press_next(); press_inc();
    chk("t2_year", edit_f0, 24);
    press_next(); press_next(); press_inc();
    chk("t2_day29", edit_f2, 29);
    press_inc();
    chk("t2_day_wrap", edit_f2, 1);
    set_date_en = 1'b0; cyc();
    wait_valid("t2_valid");
    chk("t2_tgt", wr_target, 2);
    handshake();

    // Auto-repeat
    snap_f0 = 7'd10; snap_f1 = 7'd0; snap_f2 = 7'd0;
    set_time_en = 1'b1; cyc(); cyc();
    press_next();
    key_inc = 1'b1; cyc();
    chk("t3_press", edit_f1, 1);
    for (int k = 1; k <= 800; k++) begin
      tick_ms = 1'b1;
      if (k == 800) key_inc = 1'b0;
      cyc();
      tick_ms = 1'b0;
      if (k == 500) chk("t3_tick500", edit_f1, 2);
      cyc();
    end
    chk("t3_final", edit_f1, 4);
    set_time_en = 1'b0; cyc();
    wait_valid("t3_valid");
    handshake();

    // No-edit exit in alarm mode
    snap_f0 = 7'd5; snap_f1 = 7'd6; snap_f2 = 7'd7;
    set_alarm_en = 1'b1; cyc(); cyc();
    chk("t4_f2_zero", edit_f2, 0);
    press_next();
    chk("t4_sel2", field_sel, 2);
    press_next();
    chk("t4_sel1", field_sel, 1);
    set_alarm_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin cyc(); if (wr_valid !== 1'b0) seen = 1; end
    chk("t4_no_write", seen, 0);
    chk("t4_sel_off", field_sel, 0);

    // Mode cycling, then reset during commit
    snap_f0 = 7'd8; snap_f1 = 7'd9; snap_f2 = 7'd10;
    set_time_en = 1'b1; cyc(); cyc();
    press_inc();
    set_time_en = 1'b0; set_date_en = 1'b1;
    snap_f0 = 7'd50; snap_f1 = 7'd6; snap_f2 = 7'd15;
    cyc();
    wait_valid("t5_valid");
    chk("t5_tgt_time", wr_target, 1);
    chk("t5_time_val", edit_f0, 9);
    cyc();
    handshake();
    cyc();
    chk("t5_date_load", edit_f0, 50);
    chk("t5_date_sel", field_sel, 1);
    press_inc();
    set_date_en = 1'b0; cyc();
    wait_valid("t5_valid2");
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_rst_valid", wr_valid, 0);
    chk("t5_rst_f0", edit_f0, 0);
    chk("t5_rst_sel", field_sel, 0);
    cyc();

    // Simultaneous next and inc
    snap_f0 = 7'd3; snap_f1 = 7'd4; snap_f2 = 7'd5;
    set_time_en = 1'b1; cyc(); cyc();
    key_next = 1'b1; key_inc = 1'b1; cyc();
    chk("t6_sel", field_sel, 2);
    chk("t6_f0", edit_f0, 3);
    chk("t6_f1", edit_f1, 4);
    key_next = 1'b0; key_inc = 1'b0; cyc();
    set_time_en = 1'b0; cyc(); cyc();
    chk("t6_no_write", wr_valid, 0);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        m = $urandom_range(0, 3);
        set_time_en = (m == 1); set_date_en = (m == 2); set_alarm_en = (m == 3);
      end
      snap_f0 = 7'($urandom_range(0, 127));
      snap_f1 = 7'($urandom_range(0, 15));
      snap_f2 = 7'($urandom_range(0, 40));
      if ($urandom_range(0, 5) == 0) key_next = ~key_next;
      if ($urandom_range(0, 5) == 0) key_inc = ~key_inc;
      tick_ms  = ($urandom_range(0, 3) == 0);
      wr_ready = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      cyc();
    end
    rst = 1'b0; set_time_en = 1'b0; set_date_en = 1'b0; set_alarm_en = 1'b0;
    key_next = 1'b0; key_inc = 1'b0; tick_ms = 1'b0; wr_ready = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
